// File: rtl/seg_max_sub_pkg.sv
// seg_max_sub_pkg
//   Shared definitions for the segmented max-subtract block: FSM state
//   encoding, out_kind encodings, default parameter values and a small
//   width helper.
package seg_max_sub_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_EMIT_X = 2'd1,
    ST_EMIT_F = 2'd2
  } state_t;

  localparam logic KIND_ELEM = 1'b0;   // x_i - LM[s]
  localparam logic KIND_FACT = 1'b1;   // LM[s] - GM

  localparam int DATA_W_DEF    = 16;
  localparam int SEG_LEN_DEF   = 16;
  localparam int SEG_NUM_DEF   = 4;
  localparam int CLAMP_MAG_DEF = 127;

  // Index width that never collapses to zero bits (SEG_NUM may be 1).
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/seg_max_cmp.sv
// seg_max_cmp
//   Signed running-max step. When first is set the incoming sample seeds
//   the max; otherwise the larger of din and cur_max is kept, with ties
//   keeping cur_max.
// Ports:
//   din      - incoming sample (signed, W bits)
//   cur_max  - currently stored maximum
//   first    - first sample of the group, load din unconditionally
//   next_max - maximum including din
module seg_max_cmp #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] din,
  input  logic signed [W-1:0] cur_max,
  input  logic                first,
  output logic signed [W-1:0] next_max
);

  always_comb begin
    next_max = cur_max;
    if (first)
      next_max = din;
    else if (din > cur_max)
      next_max = din;
  end

endmodule

// File: rtl/seg_max_sub.sv
// seg_max_sub
//   Collects one row of SEG_LEN*SEG_NUM signed samples, tracking each
//   segment's local max (LM) and the row's global max (GM), then streams
//   out every x_k - LM[seg(k)] followed by every LM[s] - GM. All
//   differences are formed on DATA_W+1 bits so they never wrap.
//   Optional macro SEGMAX_CLAMP_EN: differences below -CLAMP_MAG are
//   replaced by -CLAMP_MAG.
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset
//   in_valid  / in_ready  / in_data            - sample input handshake
//   out_valid / out_ready / out_data           - difference output handshake
//   out_kind  - 0 element term, 1 factor term
//   out_seg   - segment index of the current output
//   busy      - low only when idle in LOAD with nothing held
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_LOAD   | accepting samples, updating LM/GM
// ST_EMIT_X | streaming x_k - LM[k/SEG_LEN], k = 0..N-1
// ST_EMIT_F | streaming LM[s] - GM, s = 0..SEG_NUM-1
module seg_max_sub
  import seg_max_sub_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SEG_LEN   = SEG_LEN_DEF,
  parameter int SEG_NUM   = SEG_NUM_DEF,
  parameter int CLAMP_MAG = CLAMP_MAG_DEF,
  localparam int SEG_W    = clog2_min1(SEG_NUM)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W:0]   out_data,
  output logic                     out_kind,
  output logic [SEG_W-1:0]         out_seg,
  output logic                     busy
);

  localparam int N     = SEG_LEN * SEG_NUM;
  localparam int IDX_W = $clog2(N);
  localparam int LEN_W = $clog2(SEG_LEN);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] OFS_MASK = IDX_W'(SEG_LEN - 1);
  localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(SEG_NUM - 1);

  if (SEG_LEN < 2 || (SEG_LEN & (SEG_LEN - 1)) != 0) begin : g_bad_seg_len
    $error("seg_max_sub: SEG_LEN must be a power of two >= 2");
  end
  if (SEG_NUM < 1 || (SEG_NUM & (SEG_NUM - 1)) != 0) begin : g_bad_seg_num
    $error("seg_max_sub: SEG_NUM must be a power of two >= 1");
  end
  if (CLAMP_MAG < 0) begin : g_bad_clamp
    $error("seg_max_sub: CLAMP_MAG must be non-negative");
  end

`ifdef SEGMAX_CLAMP_EN
  localparam logic signed [DATA_W:0] NEG_CLAMP = -((DATA_W+1)'(CLAMP_MAG));
`endif

  function automatic logic signed [DATA_W:0] sext(input logic signed [DATA_W-1:0] v);
    return {v[DATA_W-1], v};
  endfunction

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         idx, idx_nxt;
  logic [SEG_W-1:0]         fseg, fseg_nxt;

  logic signed [DATA_W-1:0] mem [N];
  logic signed [DATA_W-1:0] lm  [SEG_NUM];
  logic signed [DATA_W-1:0] gm;

  logic                     accept, xfer;
  logic [SEG_W-1:0]         idx_seg;
  logic                     first_in_seg, first_in_row;
  logic signed [DATA_W-1:0] lm_cur, lm_next, gm_next;
  logic signed [DATA_W:0]   diff;

  assign accept       = in_valid & in_ready;
  assign xfer         = out_valid & out_ready;
  // Segment-major order: the upper index bits are the segment number.
  assign idx_seg      = SEG_W'(idx >> LEN_W);
  assign first_in_seg = (idx & OFS_MASK) == '0;
  assign first_in_row = idx == '0;
  assign lm_cur       = lm[idx_seg];
  assign busy         = !(state == ST_LOAD && idx == '0);

  seg_max_cmp #(.W(DATA_W)) u_cmp_lm (
    .din      (in_data),
    .cur_max  (lm_cur),
    .first    (first_in_seg),
    .next_max (lm_next)
  );

  seg_max_cmp #(.W(DATA_W)) u_cmp_gm (
    .din      (in_data),
    .cur_max  (gm),
    .first    (first_in_row),
    .next_max (gm_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_LOAD;
      idx   <= '0;
      fseg  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      fseg  <= fseg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    fseg_nxt  = fseg;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_kind  = KIND_ELEM;
    out_seg   = '0;
    diff      = '0;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (accept) begin
          if (idx == LAST_IDX) begin
            state_nxt = ST_EMIT_X;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      ST_EMIT_X: begin
        out_valid = 1'b1;
        out_seg   = idx_seg;
        diff      = sext(mem[idx]) - sext(lm_cur);
        if (xfer) begin
          if (idx == LAST_IDX) begin
            state_nxt = ST_EMIT_F;
            idx_nxt   = '0;
            fseg_nxt  = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      ST_EMIT_F: begin
        out_valid = 1'b1;
        out_kind  = KIND_FACT;
        out_seg   = fseg;
        diff      = sext(lm[fseg]) - sext(gm);
        if (xfer) begin
          if (fseg == LAST_SEG) begin
            state_nxt = ST_LOAD;
            fseg_nxt  = '0;
          end else begin
            fseg_nxt = fseg + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_LOAD;
        idx_nxt   = '0;
        fseg_nxt  = '0;
      end
    endcase
`ifdef SEGMAX_CLAMP_EN
    out_data = (diff < NEG_CLAMP) ? NEG_CLAMP : diff;
`else
    out_data = diff;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SEG_NUM; s++) lm[s] <= '0;
      gm <= '0;
    end else if (accept) begin
      lm[idx_seg] <= lm_next;
      gm          <= gm_next;
    end
  end

  // Sample storage holds no control state, so it is left unreset.
  always_ff @(posedge clk) begin
    if (accept) mem[idx] <= in_data;
  end

endmodule

// File: tb/tb_seg_max_sub.sv
module tb_seg_max_sub;

  localparam int DW = 16;
  localparam int SL = 16;
  localparam int SN = 4;
  localparam int N  = SL * SN;
  localparam int CM = 127;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW:0]   out_data;
  logic                 out_kind;
  logic [1:0]           out_seg;
  logic                 busy;

  always #5 clk = ~clk;

  seg_max_sub #(.DATA_W(DW), .SEG_LEN(SL), .SEG_NUM(SN), .CLAMP_MAG(CM)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_kind  (out_kind),
    .out_seg   (out_seg),
    .busy      (busy)
  );

  typedef struct {
    int data;
    int kind;
    int seg;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   ready_mode = 0;
  int   row[N];

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int clampf(input int d);
`ifdef SEGMAX_CLAMP_EN
    return (d < -CM) ? -CM : d;
`else
    return d;
`endif
  endfunction

  // Reference model: maxima by plain search over the row, then the
  // expected output sequence in emission order.
  task automatic push_expected();
    int lmax[SN];
    int gmax;
    exp_t e;
    for (int s = 0; s < SN; s++) begin
      lmax[s] = row[s*SL];
      for (int j = 1; j < SL; j++)
        if (row[s*SL+j] > lmax[s]) lmax[s] = row[s*SL+j];
    end
    gmax = lmax[0];
    for (int s = 1; s < SN; s++) if (lmax[s] > gmax) gmax = lmax[s];
    for (int k = 0; k < N; k++) begin
      e.data = clampf(row[k] - lmax[k/SL]);
      e.kind = 0;
      e.seg  = k / SL;
      exp_q.push_back(e);
    end
    for (int s = 0; s < SN; s++) begin
      e.data = clampf(lmax[s] - gmax);
      e.kind = 1;
      e.seg  = s;
      exp_q.push_back(e);
    end
  endtask

  function automatic int rand_sample();
    logic signed [DW-1:0] r;
    r = DW'($urandom);
    return int'(r);
  endfunction

  // Monitor: compares whatever the DUT presents against the queue head,
  // pops only on a transfer, so stalled cycles re-check the same entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_valid_without_expect", int'(out_valid), 0);
        end else begin
          e = exp_q[0];
          chk("out_data", int'(out_data), e.data);
          chk("out_kind", int'(out_kind), e.kind);
          chk("out_seg",  int'(out_seg),  e.seg);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // out_ready driver: 0 = held high, 1 = toggling, 2 = random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data), 0);
    chk("rst_out_kind",  int'(out_kind), 0);
    chk("rst_out_seg",   int'(out_seg), 0);
    chk("rst_busy",      int'(busy), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
  endtask

  task automatic feed(input int count, input bit gaps);
    for (int k = 0; k < count; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = DW'(row[k]);
      chk("in_ready_load", int'(in_ready), 1);
      @(posedge clk);
      #1;
      if (k == 0) chk("busy_after_first", int'(busy), 1);
    end
    in_valid = 1'b0;
  endtask

  // Sends a full row and drains it. abort_after > 0 resets that many
  // cycles into emission instead of draining.
  task automatic run_row(input int mode, input bit gaps, input bit check_bubbles,
                         input int abort_after);
    int cycles;
    ready_mode = mode;
    feed(N, gaps);
    push_expected();
    chk("latency_out_valid", int'(out_valid), 1);
    chk("emit_in_ready",     int'(in_ready), 0);
    if (abort_after > 0) begin
      repeat (abort_after) @(posedge clk);
      #1;
      do_reset();
      return;
    end
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 2000) begin
      @(posedge clk);
      #2;
      cycles++;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DW'($urandom);
    end
    in_valid = 1'b0;
    chk("drain_left", exp_q.size(), 0);
    if (check_bubbles) chk("emit_cycles", cycles, N + SN);
    chk("idle_busy",      int'(busy), 0);
    chk("idle_in_ready",  int'(in_ready), 1);
    chk("idle_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    #12;
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_busy",      int'(busy), 0);
    chk("init_out_data",  int'(out_data), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("init_in_ready", int'(in_ready), 1);

    for (int k = 0; k < N; k++) row[k] = k;
    run_row(0, 1'b0, 1'b1, 0);

    for (int k = 0; k < N; k++) row[k] = -5;
    run_row(0, 1'b0, 1'b1, 0);

    for (int k = 0; k < N; k++) row[k] = rand_sample();
    run_row(1, 1'b0, 1'b0, 0);

    for (int k = 0; k < N; k++) row[k] = $urandom_range(0, 200) - 100;
    row[0] = -300;
    row[5] = 200;
    run_row(2, 1'b1, 1'b0, 0);

    for (int k = 0; k < N; k++) row[k] = rand_sample();
    row[20] = -32768;
    row[27] = 32767;
    run_row(0, 1'b0, 1'b1, 0);

    for (int k = 0; k < N; k++) row[k] = rand_sample();
    feed(20, 1'b0);
    do_reset();
    for (int k = 0; k < N; k++) row[k] = rand_sample();
    run_row(2, 1'b1, 1'b0, 0);

    for (int k = 0; k < N; k++) row[k] = rand_sample();
    run_row(1, 1'b0, 1'b0, 10);
    for (int k = 0; k < N; k++) row[k] = k;
    run_row(0, 1'b0, 1'b1, 0);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) row[k] = rand_sample();
      run_row(2, 1'b1, 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
